alu_issue_ctrl: RTL

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl_if.sv | 26 ++
 rtl/alu_issue_ctrl.sv | 74 +++++++
 2 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Issue/ALU/debug bundle between an instruction source and alu_issue_ctrl.
// The master side offers instructions, supplies the ALU result and reads debug data.
interface alu_issue_ctrl_if;
  logic        instr_valid;
  logic [16:0] instr;
  logic        instr_ready;
  logic [2:0]  opcode;
  logic [15:0] rs_data;
  logic [15:0] rt_data;
  logic [4:0]  immediate;
  logic [15:0] ALU_out;
  logic        res_valid;
  logic [15:0] res_data;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  modport master (
    output instr_valid, instr, ALU_out, dbg_addr,
    input  instr_ready, opcode, rs_data, rt_data, immediate, res_valid, res_data, dbg_data
  );

  modport slave (
    input  instr_valid, instr, ALU_out, dbg_addr,
    output instr_ready, opcode, rs_data, rt_data, immediate, res_valid, res_data, dbg_data
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Single-issue ALU controller with an 8x16 register file (IDLE -> EXEC -> DONE).
// Define ALU_ISSUE_BACK2BACK_EN to also accept in DONE, giving one instruction per 2 cycles.
module alu_issue_ctrl (
  input logic             clk,
  input logic             rst,
  alu_issue_ctrl_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e      state_q;
  logic [15:0] regs_q [8];
  logic [2:0]  opcode_q;
  logic [2:0]  rd_q;
  logic [15:0] rs_data_q;
  logic [15:0] rt_data_q;
  logic [4:0]  imm_q;
  logic [15:0] res_data_q;
  logic        res_valid_q;
  logic        ready;
  logic        accept;

  always_comb begin
`ifdef ALU_ISSUE_BACK2BACK_EN
    ready = !rst && ((state_q == StIdle) || (state_q == StDone));
`else
    ready = !rst && (state_q == StIdle);
`endif
  end

  assign accept = bus.instr_valid & ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
      opcode_q    <= '0;
      rd_q        <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      // Accept never coincides with the EXEC write, so operands always see pre-write values.
      if (accept) begin
        opcode_q  <= bus.instr[16:14];
        rd_q      <= bus.instr[13:11];
        rs_data_q <= regs_q[bus.instr[10:8]];
        rt_data_q <= regs_q[bus.instr[7:5]];
        imm_q     <= bus.instr[4:0];
      end
      unique case (state_q)
        StIdle, StDone: state_q <= accept ? StExec : StIdle;
        StExec: begin
          regs_q[rd_q] <= bus.ALU_out;
          res_data_q   <= bus.ALU_out;
          res_valid_q  <= 1'b1;
          state_q      <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.instr_ready = ready;
  assign bus.opcode      = opcode_q;
  assign bus.rs_data     = rs_data_q;
  assign bus.rt_data     = rt_data_q;
  assign bus.immediate   = imm_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_data_q;
  assign bus.dbg_data    = regs_q[bus.dbg_addr];
endmodule
